// File: rtl/conv_layer_sequencer.sv
// Per-layer row scheduler for a bit-serial convolution unit: walks output rows, activation
// bit planes (MSB first) and kernel rows, issuing one convolution pass per tuple.
module conv_layer_sequencer #(
    parameter int unsigned KER_SIZE  = 5,
    parameter int unsigned ACT_BITS  = 3,
    parameter int unsigned ROW_BITS  = 7,
    parameter int unsigned PAR_MODES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ROW_BITS-1:0]         cfg_in_rows,
    input  logic [1:0]                  cfg_parallel,
    input  logic                        abort,
    output logic                        conv_start,
    output logic                        conv_clear,
    output logic                        conv_shift,
    output logic [ROW_BITS-1:0]         conv_act_row,
    output logic [$clog2(KER_SIZE)-1:0] conv_ker_row,
    output logic [$clog2(ACT_BITS)-1:0] conv_act_bit,
    output logic [1:0]                  conv_parallel,
    input  logic                        conv_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROW_BITS-1:0]         out_row,
    output logic                        layer_done,
    output logic                        cfg_err
);

    localparam int unsigned KER_W = $clog2(KER_SIZE);
    localparam int unsigned BIT_W = $clog2(ACT_BITS);

    localparam logic [KER_W-1:0]    KER_MAX   = KER_W'(KER_SIZE - 1);
    localparam logic [BIT_W-1:0]    BIT_MAX   = BIT_W'(ACT_BITS - 1);
    localparam logic [KER_W-1:0]    KER_ONE   = KER_W'(1);
    localparam logic [BIT_W-1:0]    BIT_ONE   = BIT_W'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE   = ROW_BITS'(1);
    localparam logic [ROW_BITS-1:0] KER_ROWS  = ROW_BITS'(KER_SIZE);
    localparam logic [2:0]          PAR_LIMIT = 3'(PAR_MODES);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEmit,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [KER_W-1:0]    ker_q, ker_d;
    logic [ROW_BITS-1:0] last_row_q, last_row_d;
    logic [1:0]          par_d;
    logic                cfg_illegal;
    logic                err_d;

    assign cfg_illegal = (cfg_in_rows < KER_ROWS) || ({1'b0, cfg_parallel} >= PAR_LIMIT);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        bit_d      = bit_q;
        ker_d      = ker_q;
        last_row_d = last_row_q;
        par_d      = conv_parallel;
        err_d      = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        if (cfg_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            last_row_d = cfg_in_rows - KER_ROWS;
                            par_d      = cfg_parallel;
                            row_d      = '0;
                            bit_d      = BIT_MAX;
                            ker_d      = '0;
                            state_d    = StIssue;
                        end
                    end
                end
                StIssue: state_d = StWait;
                StWait: begin
                    // Kernel rows are the inner loop; bit planes step down once per kernel sweep.
                    if (conv_done) begin
                        if (ker_q != KER_MAX) begin
                            ker_d   = ker_q + KER_ONE;
                            state_d = StIssue;
                        end else if (bit_q != '0) begin
                            ker_d   = '0;
                            bit_d   = bit_q - BIT_ONE;
                            state_d = StIssue;
                        end else begin
                            state_d = StEmit;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        if (row_q == last_row_q) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + ROW_ONE;
                            bit_d   = BIT_MAX;
                            ker_d   = '0;
                            state_d = StIssue;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            row_q         <= '0;
            bit_q         <= '0;
            ker_q         <= '0;
            last_row_q    <= '0;
            cfg_ready     <= 1'b1;
            conv_start    <= 1'b0;
            conv_clear    <= 1'b0;
            conv_shift    <= 1'b0;
            conv_act_row  <= '0;
            conv_ker_row  <= '0;
            conv_act_bit  <= '0;
            conv_parallel <= '0;
            out_valid     <= 1'b0;
            out_row       <= '0;
            layer_done    <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            bit_q         <= bit_d;
            ker_q         <= ker_d;
            last_row_q    <= last_row_d;
            conv_parallel <= par_d;
            cfg_ready     <= (state_d == StIdle);
            conv_start    <= (state_d == StIssue);
            conv_clear    <= (state_d == StIssue) && (bit_d == BIT_MAX) && (ker_d == '0);
            conv_shift    <= (state_d == StIssue) && (bit_d != BIT_MAX) && (ker_d == '0);
            out_valid     <= (state_d == StEmit);
            layer_done    <= (state_d == StDone);
            cfg_err       <= err_d;
            if (state_d == StIssue) begin
                conv_act_row <= row_d + ROW_BITS'(ker_d);
                conv_ker_row <= ker_d;
                conv_act_bit <= bit_d;
            end
            if (state_d == StEmit) begin
                out_row <= row_d;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: stimulus pushes expected passes and rows,
// a negedge monitor pops and compares whenever the DUT issues a pass or hands off a row.
module tb_conv_layer_sequencer;

    localparam int KER_SIZE  = 5;
    localparam int ACT_BITS  = 3;
    localparam int ROW_BITS  = 7;
    localparam int PAR_MODES = 3;

    typedef struct packed {
        logic [6:0] act;
        logic [2:0] ker;
        logic [1:0] pl;
        logic       clr;
        logic       sh;
        logic [1:0] par;
    } pass_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid, cfg_ready;
    logic [6:0] cfg_in_rows;
    logic [1:0] cfg_parallel;
    logic       abort;
    logic       conv_start, conv_clear, conv_shift;
    logic [6:0] conv_act_row;
    logic [2:0] conv_ker_row;
    logic [1:0] conv_act_bit;
    logic [1:0] conv_parallel;
    logic       conv_done;
    logic       out_valid, out_ready;
    logic [6:0] out_row;
    logic       layer_done, cfg_err;

    logic unit_done = 1'b0;
    logic stray_done = 1'b0;
    int   done_delay = 1;
    assign conv_done = unit_done | stray_done;

    int n_checks = 0, n_fail = 0;
    int start_cnt = 0, done_cnt = 0, err_cnt = 0, clr_cnt = 0, sh_cnt = 0;
    pass_t pass_q[$];
    int    out_q[$];
    pass_t got_p, exp_p;
    logic  prev_wait = 1'b0;
    logic [6:0] held_row = '0;
    int base_s, base_c, base_h, snap;

    conv_layer_sequencer #(
        .KER_SIZE (KER_SIZE),
        .ACT_BITS (ACT_BITS),
        .ROW_BITS (ROW_BITS),
        .PAR_MODES(PAR_MODES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_in_rows  (cfg_in_rows),
        .cfg_parallel (cfg_parallel),
        .abort        (abort),
        .conv_start   (conv_start),
        .conv_clear   (conv_clear),
        .conv_shift   (conv_shift),
        .conv_act_row (conv_act_row),
        .conv_ker_row (conv_ker_row),
        .conv_act_bit (conv_act_bit),
        .conv_parallel(conv_parallel),
        .conv_done    (conv_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .layer_done   (layer_done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected pass order: rows, then bit planes MSB first, then kernel rows.
    task automatic push_layer(input int rows, input int par, input int max_passes);
        int n = 0;
        for (int r = 0; r <= rows - KER_SIZE; r++) begin
            for (int b = ACT_BITS - 1; b >= 0; b--) begin
                for (int k = 0; k < KER_SIZE; k++) begin
                    pass_t p;
                    p.act = 7'(r + k);
                    p.ker = 3'(k);
                    p.pl  = 2'(b);
                    p.clr = (b == ACT_BITS - 1) && (k == 0);
                    p.sh  = (b != ACT_BITS - 1) && (k == 0);
                    p.par = 2'(par);
                    if (n < max_passes) pass_q.push_back(p);
                    n++;
                end
            end
            if (n <= max_passes) out_q.push_back(r);
        end
    endtask

    task automatic send_cfg(input int rows, input int par);
        @(posedge clk); #1;
        cfg_valid    = 1'b1;
        cfg_in_rows  = 7'(rows);
        cfg_parallel = 2'(par);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_stray();
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_cnt < target && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic wait_starts(input int target, input string name);
        int k = 0;
        while (start_cnt < target && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, start_cnt, target);
    endtask

    task automatic wait_out_valid();
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("out_valid arrives", int'(out_valid), 1);
    endtask

    task automatic check_reset_outputs();
        check("rst cfg_ready", int'(cfg_ready), 1);
        check("rst conv_start", int'(conv_start), 0);
        check("rst conv_clear", int'(conv_clear), 0);
        check("rst conv_shift", int'(conv_shift), 0);
        check("rst conv_act_row", int'(conv_act_row), 0);
        check("rst conv_ker_row", int'(conv_ker_row), 0);
        check("rst conv_act_bit", int'(conv_act_bit), 0);
        check("rst conv_parallel", int'(conv_parallel), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_row", int'(out_row), 0);
        check("rst layer_done", int'(layer_done), 0);
        check("rst cfg_err", int'(cfg_err), 0);
    endtask

    // Convolution unit model: conv_done one cycle wide, done_delay cycles after conv_start.
    initial begin
        forever begin
            @(negedge clk);
            if (conv_start) begin
                repeat (done_delay) @(posedge clk);
                #1 unit_done = 1'b1;
                @(posedge clk); #1 unit_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (prev_wait) begin
            check("out_valid held", int'(out_valid), 1);
            check("out_row held", int'(out_row), int'(held_row));
        end
        prev_wait = out_valid && !out_ready;
        held_row  = out_row;
        if (layer_done) done_cnt++;
        if (cfg_err) err_cnt++;
        if (conv_start) begin
            start_cnt++;
            if (conv_clear) clr_cnt++;
            if (conv_shift) sh_cnt++;
            got_p = {conv_act_row, conv_ker_row, conv_act_bit, conv_clear, conv_shift,
                     conv_parallel};
            n_checks++;
            if (pass_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected conv_start: got act_row=%0d ker=%0d bit=%0d, expected none",
                         got_p.act, got_p.ker, got_p.pl);
            end else begin
                exp_p = pass_q.pop_front();
                if (got_p != exp_p) begin
                    n_fail++;
                    $display("FAIL pass %0d: got act=%0d ker=%0d bit=%0d clr=%0b sh=%0b par=%0d, expected act=%0d ker=%0d bit=%0d clr=%0b sh=%0b par=%0d",
                             start_cnt, got_p.act, got_p.ker, got_p.pl, got_p.clr, got_p.sh,
                             got_p.par, exp_p.act, exp_p.ker, exp_p.pl, exp_p.clr, exp_p.sh,
                             exp_p.par);
                end
            end
        end
        if (out_valid) begin
            check("no conv_start with out_valid", int'(conv_start), 0);
            if (out_ready) begin
                if (out_q.size() == 0) check("unexpected out row", int'(out_row), -1);
                else check("out_row", int'(out_row), out_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_valid    = 1'b0;
        cfg_in_rows  = '0;
        cfg_parallel = '0;
        abort        = 1'b0;
        out_ready    = 1'b1;
        #12;
        check_reset_outputs();
        #10 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle cfg_ready", int'(cfg_ready), 1);

        // Nominal layer: 7 input rows, mode 1.
        base_s = start_cnt; base_c = clr_cnt; base_h = sh_cnt;
        push_layer(7, 1, 1000);
        send_cfg(7, 1);
        @(negedge clk);
        check("first start latency", int'(conv_start), 1);
        check("cfg_ready low after accept", int'(cfg_ready), 0);
        wait_done(1, "nominal layer_done");
        check("cfg_ready low in done cycle", int'(cfg_ready), 0);
        @(negedge clk);
        check("cfg_ready after layer_done", int'(cfg_ready), 1);
        check("nominal passes", start_cnt - base_s, 45);
        check("nominal clears", clr_cnt - base_c, 3);
        check("nominal shifts", sh_cnt - base_h, 6);
        check("nominal rows left", out_q.size(), 0);
        check("nominal passes left", pass_q.size(), 0);
        repeat (3) @(negedge clk); #1;
        check("single layer_done", done_cnt, 1);

        // Illegal configs.
        base_s = start_cnt;
        send_cfg(4, 1);
        @(negedge clk);
        check("short rows cfg_err", int'(cfg_err), 1);
        check("short rows cfg_ready", int'(cfg_ready), 1);
        check("short rows no start", int'(conv_start), 0);
        @(negedge clk);
        check("cfg_err one cycle", int'(cfg_err), 0);
        send_cfg(7, 3);
        @(negedge clk);
        check("bad mode cfg_err", int'(cfg_err), 1);
        check("bad mode cfg_ready", int'(cfg_ready), 1);
        repeat (3) @(negedge clk); #1;
        check("illegal err count", err_cnt, 2);
        check("illegal no passes", start_cnt, base_s);
        check("illegal keeps parallel", int'(conv_parallel), 1);

        // Stray done in IDLE, then backpressure with a stray done in EMIT.
        pulse_stray();
        repeat (2) @(negedge clk); #1;
        check("idle stray ignored", start_cnt, base_s);
        check("idle stray cfg_ready", int'(cfg_ready), 1);
        out_ready = 1'b0;
        push_layer(7, 0, 1000);
        send_cfg(7, 0);
        for (int r = 0; r < 3; r++) begin
            wait_out_valid();
            check("emit row", int'(out_row), r);
            if (r == 0) begin
                snap = start_cnt;
                pulse_stray();
                repeat (2) @(negedge clk); #1;
                check("emit stray no start", start_cnt, snap);
                check("emit stray out_valid", int'(out_valid), 1);
            end
            if (r == 1) begin
                snap = start_cnt;
                repeat (10) @(negedge clk);
                #1 check("backpressure no start", start_cnt, snap);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
            if (r == 1) begin
                @(negedge clk);
                check("restart after handshake", int'(conv_start), 1);
                check("restart act_row", int'(conv_act_row), 2);
            end
        end
        wait_done(2, "backpressure layer_done");
        out_ready = 1'b1;

        // Abort in WAIT of row 1, bit 1 (21st pass), coinciding with conv_done.
        base_s = start_cnt;
        push_layer(7, 2, 21);
        send_cfg(7, 2);
        wait_starts(base_s + 21, "abort reach pass");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort cfg_ready", int'(cfg_ready), 1);
        check("abort out_valid", int'(out_valid), 0);
        check("abort conv_start", int'(conv_start), 0);
        check("abort keeps parallel", int'(conv_parallel), 2);
        repeat (4) @(negedge clk); #1;
        check("abort no layer_done", done_cnt, 2);
        check("abort pass count", start_cnt, base_s + 21);
        check("abort passes left", pass_q.size(), 0);
        check("abort rows left", out_q.size(), 0);

        push_layer(6, 1, 1000);
        send_cfg(6, 1);
        @(negedge clk);
        check("post-abort start", int'(conv_start), 1);
        check("post-abort clear", int'(conv_clear), 1);
        check("post-abort bit", int'(conv_act_bit), 2);
        check("post-abort ker", int'(conv_ker_row), 0);
        check("post-abort act_row", int'(conv_act_row), 0);
        wait_done(3, "post-abort layer_done");

        // Minimal layer with a slower unit.
        done_delay = 3;
        base_s = start_cnt;
        push_layer(5, 0, 1000);
        send_cfg(5, 0);
        wait_done(4, "minimal layer_done");
        check("minimal passes", start_cnt - base_s, 15);
        check("minimal rows left", out_q.size(), 0);
        done_delay = 1;

        // Asynchronous reset in the middle of a layer.
        base_s = start_cnt;
        push_layer(5, 1, 1000);
        send_cfg(5, 1);
        wait_starts(base_s + 7, "reset reach pass");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        pass_q.delete();
        out_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        snap = start_cnt;
        repeat (6) @(negedge clk); #1;
        check("post-reset no start", start_cnt, snap);
        check("post-reset no layer_done", done_cnt, 4);
        check("post-reset no cfg_err", err_cnt, 2);
        check("post-reset cfg_ready", int'(cfg_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Per-layer row scheduler for one convolution unit. It accepts a layer configuration through a valid/ready handshake and sequences the unit through every output row. Within each row it walks every activation bit plane (MSB first, radix encoding) and every kernel row. It issues one convolution pass per (row, bit, kernel-row) tuple, hands each finished output row downstream, and sits between the layer controller and the convolution unit datapath.

## Interface
Parameters:
- KER_SIZE, 5, kernel height in rows (stride fixed at 1)
- ACT_BITS, 3, activation bit planes per row
- ROW_BITS, 7, width of row counters/addresses
- PAR_MODES, 3, number of legal parallelism modes (0 = 1 window, 1 = 2 windows, 2 = 6 windows)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  layer config valid
- cfg_ready  out  1  sequencer idle, config accepted
- cfg_in_rows  in  ROW_BITS  input feature-map height
- cfg_parallel  in  2  parallelism mode
- abort  in  1  synchronous abort, returns to IDLE
- conv_start  out  1  one-cycle pass start pulse
- conv_clear  out  1  clear accumulators, valid with conv_start
- conv_shift  out  1  shift accumulators left one bit, valid with conv_start
- conv_act_row  out  ROW_BITS  input row address for this pass
- conv_ker_row  out  $clog2(KER_SIZE)  kernel row for this pass
- conv_act_bit  out  $clog2(ACT_BITS)  activation bit plane for this pass
- conv_parallel  out  2  latched parallelism mode, stable for the whole layer
- conv_done  in  1  pass-complete pulse from the unit
- out_valid  out  1  output row complete
- out_ready  in  1  downstream accepts the row
- out_row  out  ROW_BITS  index of the completed output row
- layer_done  out  1  one-cycle pulse after the last row is accepted
- cfg_err  out  1  one-cycle pulse when an illegal config is rejected

## Operation
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - cfg_ready=1.
  - A config is illegal if cfg_in_rows<KER_SIZE or cfg_parallel≥PAR_MODES. On cfg_valid with an illegal config: pulse cfg_err next cycle, latch nothing, stay in IDLE.
  - On cfg_valid with a legal config: latch cfg_in_rows and cfg_parallel; set row=0, bit=ACT_BITS-1, ker=0; go to ISSUE.
- Output row count: last_row = cfg_in_rows-KER_SIZE. Total passes = (last_row+1)·ACT_BITS·KER_SIZE.
- ISSUE (one cycle), then go to WAIT. Registered outputs in this cycle:
  - conv_start=1.
  - conv_act_row=row+ker, conv_ker_row=ker, conv_act_bit=bit.
  - conv_clear=1 iff bit==ACT_BITS-1 and ker==0.
  - conv_shift=1 iff bit!=ACT_BITS-1 and ker==0.
- WAIT: holds until conv_done. On conv_done:
  - If ker<KER_SIZE-1: ker+1, go to ISSUE.
  - Else if bit>0: ker=0, bit-1, go to ISSUE.
  - Else: go to EMIT.
- EMIT: out_valid=1 and out_row=row, both held stable until out_ready. On the handshake:
  - If row==last_row: go to DONE.
  - Else: row+1, bit=ACT_BITS-1, ker=0, go to ISSUE.
- DONE: layer_done=1 for one cycle, then go to IDLE.
- conv_done outside WAIT is ignored.
- conv_done in the ISSUE cycle is ignored; the unit must not assert it before the cycle after conv_start.
- abort:
  - Has priority over every transition.
  - Next cycle: state=IDLE, all pulse outputs 0, out_valid=0. No layer_done is issued.
  - conv_parallel keeps its last value.
- Counters never wrap: ker≤KER_SIZE-1, bit≤ACT_BITS-1, row≤last_row.

## Timing
- All outputs are registered.
- Reset values: cfg_ready=1; every other output, including conv_parallel, is 0. State=IDLE.
- Config accept to first conv_start: 1 cycle (cfg_valid·cfg_ready in cycle t gives conv_start in cycle t+1).
- conv_done in cycle t gives the next conv_start in cycle t+1, or out_valid in t+1 after the final pass of a row.
- Minimum pass period: 2 cycles (ISSUE + one WAIT cycle).
- out_valid·out_ready in cycle t gives the next conv_start in t+1, or layer_done in t+1 after the last row.
- cfg_ready=0 from the cycle after acceptance until the cycle after layer_done.
- Reset asserted mid-layer returns to IDLE immediately (asynchronous). No pulses are issued during or after reset.

## Test plan
- Nominal layer: in_rows=7, parallel=1, conv_done 1 cycle after each start, out_ready=1.
  - 3 output rows and 45 conv_start pulses.
  - Row 0 tuples: (act_row,ker,bit) = (0,0,2),(1,1,2)…(4,4,2),(0,0,1)…(4,4,0).
  - conv_clear on passes 0, 15 and 30; conv_shift on passes 5, 10, 20, 25, 35 and 40.
  - out_row 0,1,2; layer_done exactly once.
- Illegal configs: in_rows=4 → cfg_err pulse, no conv_start, cfg_ready stays 1. parallel=3 → same response.
- Backpressure: out_ready held low 10 cycles at row 1 → out_valid and out_row=1 held stable; no conv_start until the handshake, then start with act_row=2.
- Stray done: conv_done pulsed in IDLE and in EMIT → ignored, pass count unchanged.
- Abort mid-WAIT at row 1, bit 1 → IDLE next cycle, cfg_ready=1, no layer_done. A new config then starts at row 0, bit 2, ker 0 with conv_clear=1.
- Minimal layer: in_rows=5 → 15 passes, single out_row=0. Also assert rst_n low mid-layer → all outputs return to reset values immediately.
